// File: rtl/scan_pkg.sv
// Shared definitions for the truth-table scanner: state encoding, widths
// and the row-to-bit mapping used when assembling the measured table.
package scan_pkg;

   localparam int ROW_W = 3;
   localparam int TT_W  = 8;

   typedef enum logic [2:0] {
      IDLE,
      APPLY,
      SETTLE,
      SAMPLE_A,
      SAMPLE_B,
      DONE
   } scan_state_t;

   // The first row scanned lands in the MSB of the table, so row r maps to
   // bit (TT_W-1-r).
   function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] r);
      return 3'd7 - r;
   endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable 8-bit down-counter used to hold each input row for the settle
// time before the output is sampled. The zero flag is combinational so the
// FSM can leave SETTLE on the same edge the count reaches zero.
module settle_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_value,
   input  logic       dec,
   output logic       zero
);

   logic [7:0] count;

   // Load takes precedence over decrement; the counter parks at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= 8'd0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

   assign zero = (count == 8'd0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks all eight input rows of a 3-input combinational circuit, holds each
// row for a programmable settle time, samples the circuit output twice to
// catch instability, and compares the assembled truth table with EXPECTED.
module truth_table_scanner
   import scan_pkg::*;
#(
   parameter int unsigned     SETTLE_CYCLES = 4,
   parameter logic [TT_W-1:0] EXPECTED      = 8'h9C
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   output logic            dut_in1,
   output logic            dut_in2,
   output logic            dut_in3,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic [TT_W-1:0] table_q,
   output logic [TT_W-1:0] mismatch,
   output logic [TT_W-1:0] unstable,
   output logic            pass
);

   // The timer counts down from SETTLE_CYCLES-1 to zero inclusive, which
   // gives exactly SETTLE_CYCLES cycles in SETTLE.
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = 3'd7;

   scan_state_t      state;
   logic [ROW_W-1:0] row;
   logic [ROW_W-1:0] drive_row;
   logic             s_a;
   logic             timer_load;
   logic             timer_dec;
   logic             timer_zero;

   assign timer_load = (state == APPLY);
   assign timer_dec  = (state == SETTLE);

   settle_timer u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (timer_load),
      .load_value (SETTLE_LOAD),
      .dec        (timer_dec),
      .zero       (timer_zero)
   );

   // in1 is the MSB of the row index.
   assign dut_in1 = drive_row[2];
   assign dut_in2 = drive_row[1];
   assign dut_in3 = drive_row[0];

   // Scan sequencer: row stepping, output capture and result computation.
   // drive_row is advanced on the SAMPLE_B edge so the next row is already
   // on the circuit inputs during its APPLY cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         row       <= '0;
         drive_row <= '0;
         s_a       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         table_q   <= '0;
         mismatch  <= '0;
         unstable  <= '0;
         pass      <= 1'b0;
      end else if (abort && (state != IDLE)) begin
         state     <= IDLE;
         row       <= '0;
         drive_row <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mismatch  <= '0;
         pass      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && !abort) begin
                  state     <= APPLY;
                  busy      <= 1'b1;
                  row       <= '0;
                  drive_row <= '0;
                  table_q   <= '0;
                  unstable  <= '0;
                  pass      <= 1'b0;
               end else begin
                  busy <= 1'b0;
               end
            end
            APPLY: begin
               state <= SETTLE;
            end
            SETTLE: begin
               if (timer_zero) begin
                  state <= SAMPLE_A;
               end
            end
            SAMPLE_A: begin
               s_a   <= dut_out;
               state <= SAMPLE_B;
            end
            SAMPLE_B: begin
               table_q[row_to_bit(row)] <= s_a;
               if (dut_out != s_a) begin
                  unstable[row_to_bit(row)] <= 1'b1;
               end
               if (row == LAST_ROW) begin
                  state <= DONE;
               end else begin
                  row       <= row + 3'd1;
                  drive_row <= row + 3'd1;
                  state     <= APPLY;
               end
            end
            DONE: begin
               done      <= 1'b1;
               mismatch  <= table_q ^ EXPECTED;
               pass      <= (table_q == EXPECTED) && (unstable == '0);
               row       <= '0;
               drive_row <= '0;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner: table-driven full scans
// against a modelled 0x9C circuit and constant circuits, plus hand-written
// sequences for abort, reset mid-scan and a short settle time.
module tb_truth_table_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start;
   logic       abort;
   logic       dut_in1, dut_in2, dut_in3;
   logic       dut_out;
   logic       busy, done, pass;
   logic [7:0] table_q, mismatch, unstable;

   logic       start_f;
   logic       f_in1, f_in2, f_in3;
   logic       dut_out_f;
   logic       busy_f, done_f, pass_f;
   logic [7:0] table_f, mismatch_f, unstable_f;

   int   mode;
   logic glitch;

   int checks = 0;
   int passes = 0;

   truth_table_scanner u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .dut_in1  (dut_in1),
      .dut_in2  (dut_in2),
      .dut_in3  (dut_in3),
      .dut_out  (dut_out),
      .busy     (busy),
      .done     (done),
      .table_q  (table_q),
      .mismatch (mismatch),
      .unstable (unstable),
      .pass     (pass)
   );

   truth_table_scanner #(.SETTLE_CYCLES(2), .EXPECTED(8'h9C)) u_fast (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_f),
      .abort    (1'b0),
      .dut_in1  (f_in1),
      .dut_in2  (f_in2),
      .dut_in3  (f_in3),
      .dut_out  (dut_out_f),
      .busy     (busy_f),
      .done     (done_f),
      .table_q  (table_f),
      .mismatch (mismatch_f),
      .unstable (unstable_f),
      .pass     (pass_f)
   );

   // Circuit under characterisation: mode 0 = 0x9C circuit (optionally
   // glitched), 1 = constant 1, 3 = constant 0.
   always_comb begin
      dut_out = ~(dut_in2 ^ (dut_in3 & ~dut_in1)) ^ glitch;
      if (mode == 1) dut_out = 1'b1;
      else if (mode == 3) dut_out = 1'b0;
   end

   assign dut_out_f = ~(f_in2 ^ (f_in3 & ~f_in1));

   typedef struct {
      int         mode;
      int         glitch_edge;
      int         restart_edge;
      logic [7:0] exp_table;
      logic [7:0] exp_mismatch;
      logic [7:0] exp_unstable;
      logic       exp_pass;
      int         exp_done;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Runs one full scan; edge 0 is the edge that accepts start.
   task automatic apply_stimulus(input int mode_i, input int glitch_edge, input int restart_edge,
                                 output int done_cyc, output logic busy1,
                                 output logic [2:0] in_at8, output logic [2:0] in_at56);
      mode     = mode_i;
      glitch   = 1'b0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
      done_cyc = -1;
      busy1    = 1'b0;
      in_at8   = 3'bxxx;
      in_at56  = 3'bxxx;
      for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
         tick();
         glitch = (c == glitch_edge);
         start  = (c == restart_edge);
         if (c == 1) busy1 = busy;
         if (c == 8) in_at8 = {dut_in1, dut_in2, dut_in3};
         if (c == 56) in_at56 = {dut_in1, dut_in2, dut_in3};
         if (done) done_cyc = c;
      end
      glitch = 1'b0;
      start  = 1'b0;
   endtask

   initial begin
      int         done_cyc;
      logic       busy1;
      logic [2:0] in8, in56;
      int         seen;

      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      start_f = 1'b0;
      mode    = 0;
      glitch  = 1'b0;

      vecs[0] = '{0, -1, -1, 8'h9C, 8'h00, 8'h00, 1'b1, 57};
      vecs[1] = '{1, -1, -1, 8'hFF, 8'h63, 8'h00, 1'b0, 57};
      vecs[2] = '{0, 27, -1, 8'h9C, 8'h00, 8'h10, 1'b0, 57};
      vecs[3] = '{3, -1, 20, 8'h00, 8'h9C, 8'h00, 1'b0, 57};

      tick();
      tick();
      check_output("reset_busy", busy, 0);
      check_output("reset_done", done, 0);
      check_output("reset_table", table_q, 0);
      check_output("reset_mismatch", mismatch, 0);
      check_output("reset_unstable", unstable, 0);
      check_output("reset_pass", pass, 0);
      check_output("reset_dut_in", {dut_in1, dut_in2, dut_in3}, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) begin
         apply_stimulus(vecs[i].mode, vecs[i].glitch_edge, vecs[i].restart_edge,
                        done_cyc, busy1, in8, in56);
         $display("[TB] vector %0d done at cycle %0d", i, done_cyc);
         check_output("done_cycle", done_cyc, vecs[i].exp_done);
         check_output("busy_after_start", busy1, 1);
         check_output("dut_in_row1", in8, 3'd1);
         check_output("dut_in_done_row7", in56, 3'd7);
         check_output("table_q", table_q, vecs[i].exp_table);
         check_output("mismatch", mismatch, vecs[i].exp_mismatch);
         check_output("unstable", unstable, vecs[i].exp_unstable);
         check_output("pass", pass, vecs[i].exp_pass);
         check_output("busy_with_done", busy, 1);
         tick();
         check_output("done_one_cycle", done, 0);
         check_output("busy_after_done", busy, 0);
         check_output("pass_held", pass, vecs[i].exp_pass);
         check_output("dut_in_idle", {dut_in1, dut_in2, dut_in3}, 0);
         tick();
      end

      // Abort during SETTLE of row 4 (row 4 APPLY is on edge 29).
      mode  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (30) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_output("abort_busy", busy, 0);
      check_output("abort_done", done, 0);
      check_output("abort_table", table_q, 8'h90);
      check_output("abort_pass", pass, 0);
      check_output("abort_mismatch", mismatch, 0);
      check_output("abort_dut_in", {dut_in1, dut_in2, dut_in3}, 0);
      seen = 0;
      for (int c = 0; c < 70; c++) begin
         tick();
         if (done || busy) seen++;
      end
      check_output("abort_stays_idle", seen, 0);

      // abort together with start in IDLE: start is dropped.
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      check_output("abort_start_idle_busy", busy, 0);
      tick();
      check_output("abort_start_idle_busy2", busy, 0);

      // Reset mid-scan.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      check_output("midscan_busy_before_reset", busy, 1);
      rst_n = 1'b0;
      tick();
      check_output("midrst_busy", busy, 0);
      check_output("midrst_done", done, 0);
      check_output("midrst_table", table_q, 0);
      check_output("midrst_mismatch", mismatch, 0);
      check_output("midrst_unstable", unstable, 0);
      check_output("midrst_pass", pass, 0);
      check_output("midrst_dut_in", {dut_in1, dut_in2, dut_in3}, 0);
      rst_n = 1'b1;
      tick();

      // Short settle time instance.
      start_f  = 1'b1;
      tick();
      start_f  = 1'b0;
      done_cyc = -1;
      for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
         tick();
         if (done_f) done_cyc = c;
      end
      check_output("fast_done_cycle", done_cyc, 41);
      check_output("fast_table", table_f, 8'h9C);
      check_output("fast_unstable", unstable_f, 8'h00);
      check_output("fast_pass", pass_f, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential characterisation stage that drives the 3-input combinational logic circuits (in1, in2, in3 -> out) and consumes their output. On `start` it walks all eight input rows, holds each for a programmable settle time, samples `out` twice to detect instability, and assembles the measured 8-bit truth table. It then compares the table against an expected hex code, such as 0x9C. The block sits directly around one circuit instance in the circuit-score test benches and FPGA harnesses, replacing hand-written exhaustive stimulus.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles each row is held before the first sample; legal range 2..255.
- `EXPECTED`, default 8'h9C: reference truth table, using the bit ordering defined under Operation.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- `abort`  in  1  returns the block to IDLE next cycle; takes priority over everything except reset.
- `dut_in1`, `dut_in2`, `dut_in3`  out  1 each  drive the circuit's in1, in2, in3.
- `dut_out`  in  1  the circuit's out.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle pulse when the result is valid.
- `table_q`  out  8  measured truth table.
- `mismatch`  out  8  `table_q ^ EXPECTED`.
- `unstable`  out  8  per-row flag: the two samples of that row differed.
- `pass`  out  1  `mismatch == 0` and `unstable == 0`; valid with `done` and held until the next accepted `start`.

## Operation
- Row index: r = {in1, in2, in3}, with in1 as the MSB. Rows are scanned in order r = 0..7.
- The result for row r is stored in `table_q[7-r]`, so the first row scanned lands in the MSB. With this ordering, the circuit out = ~(in2 ^ (in3 & ~in1)) yields 8'h9C.
- State machine:
  - IDLE: `start` moves to APPLY and clears `table_q`, `unstable` and `pass`.
  - APPLY: drive row r for one cycle, load the settle counter with SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: decrement the counter; at zero go to SAMPLE_A.
  - SAMPLE_A: capture `dut_out` into a register s_a.
  - SAMPLE_B: compare `dut_out` with s_a. Write s_a to `table_q[7-r]` and set `unstable[7-r]` if they differ. If r = 7 go to DONE, else increment r and go to APPLY.
  - DONE: pulse `done` for one cycle, compute `mismatch` and `pass`, return to IDLE.
- `dut_in*` hold the current row from APPLY through SAMPLE_B, and hold row 7 through DONE. In IDLE they return to 3'b000.
- `start` is ignored while `busy`; no request is queued.
- On `abort` mid-scan:
  - go to IDLE and do not pulse `done`;
  - `table_q` keeps the rows captured so far;
  - `pass` = 0 and `mismatch` = 0.
- `abort` asserted together with `start` in IDLE: `start` is ignored.
- Counters: row counter is 3 bits and wraps only through DONE. The settle counter is 8 bits.

## Timing
- Reset values (rst_n low at a rising edge): state IDLE, `dut_in*` = 0, `busy` = 0, `done` = 0, `table_q` = 0, `mismatch` = 0, `unstable` = 0, `pass` = 0, row = 0.
- Reset mid-scan behaves as above on the next edge.
- Per row: 1 (APPLY) + SETTLE_CYCLES + 2 (samples) cycles.
- Full scan: `done` rises 8·(SETTLE_CYCLES+3)+1 cycles after the `start` edge. With the default this is 57 cycles.
- `dut_out` is sampled combinationally in the same clock domain; the DUT path must close timing within one cycle.
- `done` and `pass` are registered outputs.

## Structure
- Shared package `scan_pkg` holds:
  - the state enum (IDLE, APPLY, SETTLE, SAMPLE_A, SAMPLE_B, DONE);
  - ROW_W = 3 and TT_W = 8;
  - the function `row_to_bit(r) = 7 - r`.
- One sub-module is natural: `settle_timer`, a loadable down-counter with a `zero` flag. The FSM, row counter and capture registers live in the top level.

## Test plan
- DUT = 0x9C circuit, `start` pulse: `done` at cycle 57, `table_q` = 8'h9C, `mismatch` = 0, `unstable` = 0, `pass` = 1.
- DUT replaced by constant 1: `table_q` = 8'hFF, `mismatch` = 8'h63, `pass` = 0.
- DUT output inverted on the SAMPLE_B cycle of row 3: `unstable` = 8'h10, `table_q` = 8'h9C, `pass` = 0.
- `abort` during the SETTLE of row 4:
  - IDLE next cycle, no `done`, `busy` = 0;
  - `table_q` upper nibble = 4'h9, lower nibble = 0.
- `start` re-pulsed mid-scan: ignored, and `done` timing unchanged. `rst_n` low mid-scan: all outputs return to reset values the next cycle.
- SETTLE_CYCLES = 2: `done` at cycle 41 with `table_q` = 8'h9C.
